// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared DVS event queue sizing, event word type and output FSM states
package dvs_ravens_pkg;
  localparam int EVENT_QUEUE_DEPTH = 4;
  localparam int EVENT_BITS = 8;
  typedef logic [EVENT_BITS-1:0] event_t;
  typedef enum logic [1:0] {OUT_EMPTY, OUT_FETCH, OUT_VALID} out_state_t;
endpackage

// File: rtl/event_queue_ctrl.sv
// event_queue_ctrl: FIFO controller over single-port SRAM (push in_*, pop out_*, sram_* port, count/full/empty)
module event_queue_ctrl
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH = EVENT_QUEUE_DEPTH,
  parameter int WIDTH = EVENT_BITS,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW-1:0]    sram_addr,
  output logic [WIDTH-1:0] sram_d_in,
  output logic             sram_wr_en,
  output logic             sram_sense_en,
  input  logic [WIDTH-1:0] sram_d_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  out_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic pop, rd, wr;
  assign out_valid = state_q == OUT_VALID;
  assign pop = out_valid && out_ready;
  assign rd = !rst && count_q != '0 && (state_q == OUT_EMPTY || pop);
  assign in_ready = !rst && count_q < CW'(DEPTH) && !rd;
  assign wr = in_valid && in_ready;
  assign sram_addr = rd ? rd_ptr_q : wr_ptr_q;
  assign sram_d_in = in_data;
  assign sram_wr_en = wr;
  assign sram_sense_en = rd;
  assign out_data = sram_d_out;
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  always_comb begin
    wr_ptr_d = wr ? (wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = rd ? (rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d = count_q + CW'(wr) - CW'(rd);
    state_d = state_q == OUT_EMPTY ? (rd ? OUT_FETCH : OUT_EMPTY) :
              state_q == OUT_FETCH ? OUT_VALID :
              (pop && !rd) ? OUT_EMPTY : OUT_VALID;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CW'(DEPTH));
      assert (!(sram_wr_en && sram_sense_en));
    end
  end
  assert property (@(posedge clk) disable iff (rst) out_valid && !out_ready |=> $stable(out_data));
endmodule
